// File: rtl/trigger_ctrl.sv
// Trigger sequencer: decodes SUMP trigger/flow opcodes into per-stage config
// strobes and an arm pulse, and tracks trigger level and capture-run state.
module trigger_ctrl #(
  parameter int NSTAGES = 4
) (
  input  logic               clk_i,
  input  logic               rst_in,
  input  logic               exec_i,
  input  logic [7:0]         opcode_i,
  input  logic [NSTAGES-1:0] match_i,
  input  logic [NSTAGES-1:0] run_i,
  output logic [NSTAGES-1:0] set_mask_o,
  output logic [NSTAGES-1:0] set_val_o,
  output logic [NSTAGES-1:0] set_cfg_o,
  output logic               arm_o,
  output logic [1:0]         lvl_o,
  output logic               armed_o,
  output logic               run_o,
  output logic               cfg_drop_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } state_e;

  localparam logic [2:0] NSTAGES_W = 3'(NSTAGES);

  state_e             state_q, state_d;
  logic [NSTAGES-1:0] set_mask_q, set_mask_d;
  logic [NSTAGES-1:0] set_val_q, set_val_d;
  logic [NSTAGES-1:0] set_cfg_q, set_cfg_d;
  logic               arm_q, arm_d;
  logic [1:0]         lvl_q, lvl_d;
  logic               armed_q, armed_d;
  logic               run_q, run_d;
  logic               cfg_drop_q, cfg_drop_d;

  logic               is_reset;
  logic               is_arm;
  logic               is_set;
  logic               stage_ok;
  logic [1:0]         stage_idx;
  logic [1:0]         set_kind;
  logic [NSTAGES-1:0] stage_oh;

  // Opcode decode; stage indices beyond the instantiated bank are ignored.
  always_comb begin
    stage_idx = opcode_i[3:2];
    set_kind  = opcode_i[1:0];
    is_reset  = exec_i && (opcode_i == 8'h00);
    is_arm    = exec_i && (opcode_i == 8'h01);
    stage_ok  = ({1'b0, stage_idx} < NSTAGES_W);
    is_set    = exec_i && (opcode_i[7:4] == 4'hC) && (set_kind != 2'b11) && stage_ok;
    stage_oh  = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      stage_oh[i] = (stage_idx == 2'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    set_mask_d = '0;
    set_val_d  = '0;
    set_cfg_d  = '0;
    arm_d      = 1'b0;
    lvl_d      = lvl_q;
    run_d      = run_q;
    cfg_drop_d = 1'b0;

    if (is_reset) begin
      state_d = IDLE;
      lvl_d   = 2'd0;
      run_d   = 1'b0;
    end else if (is_arm) begin
      state_d = ARMED;
      arm_d   = 1'b1;
      lvl_d   = 2'd0;
      run_d   = 1'b0;
    end else begin
      // Any number of simultaneous matches advances the level by one step.
      if ((state_q == ARMED) && (|match_i)) begin
        lvl_d = (lvl_q == 2'd3) ? 2'd3 : lvl_q + 2'd1;
        if (|(match_i & run_i)) begin
          state_d = TRIGGERED;
          run_d   = 1'b1;
        end
      end
      if (is_set) begin
        if (state_q == IDLE) begin
          set_mask_d = (set_kind == 2'b00) ? stage_oh : '0;
          set_val_d  = (set_kind == 2'b01) ? stage_oh : '0;
          set_cfg_d  = (set_kind == 2'b10) ? stage_oh : '0;
        end else begin
          cfg_drop_d = 1'b1;
        end
      end
    end

    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      set_mask_q <= '0;
      set_val_q  <= '0;
      set_cfg_q  <= '0;
      arm_q      <= 1'b0;
      lvl_q      <= 2'd0;
      armed_q    <= 1'b0;
      run_q      <= 1'b0;
      cfg_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_mask_q <= set_mask_d;
      set_val_q  <= set_val_d;
      set_cfg_q  <= set_cfg_d;
      arm_q      <= arm_d;
      lvl_q      <= lvl_d;
      armed_q    <= armed_d;
      run_q      <= run_d;
      cfg_drop_q <= cfg_drop_d;
    end
  end

  assign set_mask_o = set_mask_q;
  assign set_val_o  = set_val_q;
  assign set_cfg_o  = set_cfg_q;
  assign arm_o      = arm_q;
  assign lvl_o      = lvl_q;
  assign armed_o    = armed_q;
  assign run_o      = run_q;
  assign cfg_drop_o = cfg_drop_q;

endmodule

// File: doc/trigger_ctrl.md
# trigger_ctrl

Sequencer and configuration router for the bank of trigger stages in the logic analyzer. Decodes SUMP trigger and flow opcodes from the command decoder into per-stage one-hot configuration strobes and a broadcast arm pulse. Tracks the active trigger level from stage matches and raises the capture-run flag for the sampler/memory controller. Sits between the command decoder and the `stage` instances.

## Interface
- `NSTAGES`, default 4: number of instantiated trigger stages; legal range 1..4.
- `clk_i` input 1: system clock.
- `rst_in` input 1: asynchronous reset, active low.
- `exec_i` input 1: single-cycle strobe; `opcode_i` is valid.
- `opcode_i` input 8: SUMP short-command opcode.
- `match_i` input NSTAGES: per-stage match pulse, bit n from stage n.
- `run_i` input NSTAGES: per-stage run pulse, coincident with the matching `match_i` bit.
- `set_mask_o` output NSTAGES: one-hot pulse, load mask into stage n.
- `set_val_o` output NSTAGES: one-hot pulse, load value into stage n.
- `set_cfg_o` output NSTAGES: one-hot pulse, load config into stage n.
- `arm_o` output 1: broadcast arm pulse to all stages.
- `lvl_o` output 2: current trigger level, fed to every stage's `lvl_i`.
- `armed_o` output 1: high while state is ARMED.
- `run_o` output 1: sticky capture-run flag.
- `cfg_drop_o` output 1: pulse, config opcode rejected.

## Operation
- Opcode decode, with n = opcode[3:2]:
  - 0x00 is RESET.
  - 0x01 is ARM.
  - 0xC0|n<<2 is SET_MASK for stage n.
  - 0xC1|n<<2 is SET_VAL for stage n.
  - 0xC2|n<<2 is SET_CFG for stage n.
  - All other opcodes are ignored with no output effect, including 0xC3|n<<2 and any n >= NSTAGES.
- State machine: IDLE, ARMED, TRIGGERED. Reset state is IDLE.
- RESET, accepted in any state:
  - next state IDLE, `lvl_o`=0, `run_o`=0.
  - No strobes are issued.
- ARM, accepted in any state:
  - `arm_o` pulses; next state ARMED.
  - `lvl_o`=0, `run_o`=0. Re-arming from ARMED or TRIGGERED restarts the sequence.
- SET_*:
  - In IDLE: the matching one-hot bit pulses for one cycle.
  - In ARMED or TRIGGERED: no strobe; `cfg_drop_o` pulses for one cycle.
- In ARMED, when any bit of `match_i` is high:
  - `lvl_o` increments by exactly 1, regardless of how many bits are set.
  - `lvl_o` saturates at 3.
- In ARMED, when any bit of (`match_i` & `run_i`) is high:
  - next state TRIGGERED, `run_o`=1.
  - The level increment for that same cycle still applies.
- In TRIGGERED: `match_i`/`run_i` are ignored; `run_o` and `lvl_o` hold until RESET or ARM.
- In IDLE: `match_i`/`run_i` are ignored.
- Simultaneous `exec_i` (RESET or ARM) and `match_i` in the same cycle: the command wins and the match is discarded. SET_* with a match in ARMED: the match is processed and the SET_* is dropped.

## Timing
- All outputs are registered.
- Reset values: strobes 0, `arm_o`=0, `lvl_o`=0, `armed_o`=0, `run_o`=0, `cfg_drop_o`=0.
- Asynchronous assertion of `rst_in` clears all state immediately, mid-sequence included. Deassertion is taken synchronously by the clock.
- Command latency: strobe, `arm_o`, `cfg_drop_o` and the state change are visible one cycle after the `exec_i` cycle.
- Strobes are exactly one cycle wide. At most one of set_mask/set_val/set_cfg/arm is high in any cycle.
- Match latency: `lvl_o` and `run_o` update one cycle after the `match_i` cycle.
- Because of that one-cycle latency, stages see the new level from the following sample onward.
- Back-to-back `exec_i` on consecutive cycles is supported; each is decoded independently.

## Test plan
- Reset, then exec 0xC4, 0xC5, 0xC6 with NSTAGES=4 -> `set_mask_o`=0010, `set_val_o`=0010, `set_cfg_o`=0010 on consecutive cycles, each one cycle wide, no `cfg_drop_o`.
- NSTAGES=2, exec 0xC8 and 0xC3 -> no strobe, no `cfg_drop_o`, state stays IDLE.
- Exec 0x01, then `match_i`=0001 with `run_i`=0, then `match_i`=0110 with `run_i`=0, then `match_i`=1000 with `run_i`=1000 -> `arm_o` one pulse, `lvl_o` 0→1→2→3, `run_o`=1 the cycle after the last match, state TRIGGERED.
- In ARMED at `lvl_o`=3, `match_i`=0001 with `run_i`=0 -> `lvl_o` stays 3.
- In ARMED, exec 0xC0 -> no `set_mask_o`, `cfg_drop_o` pulses once.
- In TRIGGERED, exec 0x01 in the same cycle as `match_i`=1111 with `run_i`=1111 -> `arm_o` pulses, `lvl_o`=0, `run_o`=0, `armed_o`=1, match ignored.
- Drop `rst_in` asynchronously mid-ARMED at `lvl_o`=2 -> all outputs 0 before the next clock edge.
